jk_bank_sequencer: RTL and testbench

//  Controller for a W-bit bank of JK flip-flop cells (the arithmetic unit's state register).

---
 rtl/jk_bank_sequencer.sv | 141 ++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - one-op-at-a-time J/K sequencer for a W-bit JK flip-flop bank
module jk_bank_sequencer #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         req,
   input  logic [2:0]   op,
   input  logic [W-1:0] din,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         ovf,
   output logic         err,
   output logic [W-1:0] jk_j,
   output logic [W-1:0] jk_k,
   output logic         jk_en,
   output logic         jk_rst_n,
   input  logic [W-1:0] q_in
);

   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_INC  = 3'd2;
   localparam logic [2:0] OP_DEC  = 3'd3;
   localparam logic [2:0] OP_SHL  = 3'd4;
   localparam logic [2:0] OP_SHR  = 3'd5;
   localparam logic [2:0] OP_CMPL = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [W-1:0] din_q, din_d;
   logic [W-1:0] result_q, result_d;
   logic         ovf_q, ovf_d;
   logic         err_q, err_d;

   logic [W-1:0] t_inc, t_dec, n_shl, n_shr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         din_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         din_q    <= din_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = S_APPLY;
         S_APPLY: state_d = S_CHECK;
         S_CHECK: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Toggle masks and shifted images, all derived from the pre-op bank value.
   always_comb begin
      t_inc = '0;
      t_dec = '0;
      t_inc[0] = 1'b1;
      t_dec[0] = 1'b1;
      for (int i = 1; i < W; i++) begin
         t_inc[i] = t_inc[i-1] & q_in[i-1];
         t_dec[i] = t_dec[i-1] & ~q_in[i-1];
      end
      n_shl = {q_in[W-2:0], din_q[0]};
      n_shr = {din_q[W-1], q_in[W-1:1]};
   end

   always_comb begin
      op_d     = op_q;
      din_d    = din_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d  = op;
               din_d = din;
               ovf_d = 1'b0;
               err_d = 1'b0;
            end
         end
         S_APPLY: begin
            err_d = (op_q == OP_ILL);
            case (op_q)
               OP_INC:  ovf_d = &q_in;
               OP_DEC:  ovf_d = ~|q_in;
               OP_SHL:  ovf_d = q_in[W-1];
               OP_SHR:  ovf_d = q_in[0];
               default: ovf_d = 1'b0;
            endcase
         end
         S_CHECK: result_d = q_in;
         default: ;
      endcase
   end

   always_comb begin
      ready    = (state_q == S_IDLE);
      busy     = ~ready;
      done     = (state_q == S_DONE);
      result   = result_q;
      ovf      = ovf_q;
      err      = err_q;
      jk_rst_n = ~RST;
      jk_j     = '0;
      jk_k     = '0;
      jk_en    = 1'b0;
      if (state_q == S_APPLY) begin
         jk_en = (op_q != OP_ILL);
         case (op_q)
            OP_CLR:  begin jk_j = '0;      jk_k = '1;      end
            OP_LOAD: begin jk_j = din_q;   jk_k = ~din_q;  end
            OP_INC:  begin jk_j = t_inc;   jk_k = t_inc;   end
            OP_DEC:  begin jk_j = t_dec;   jk_k = t_dec;   end
            OP_SHL:  begin jk_j = n_shl;   jk_k = ~n_shl;  end
            OP_SHR:  begin jk_j = n_shr;   jk_k = ~n_shr;  end
            OP_CMPL: begin jk_j = '1;      jk_k = '1;      end
            default: begin jk_j = '0;      jk_k = '0;      end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - directed and randomized checks of jk_bank_sequencer against an arithmetic model
module tb_jk_bank_sequencer;

   localparam int W = 4;
   localparam logic [W-1:0] MASK = '1;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         req = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] din = '0;
   logic         ready, busy, done, ovf, err, jk_en, jk_rst_n;
   logic [W-1:0] result, jk_j, jk_k, q_in;
   logic [W-1:0] bank;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] m = '0;
   logic         m_ovf = 1'b0;
   logic         m_err = 1'b0;

   jk_bank_sequencer #(.W(W)) dut (
      .CLK(CLK), .RST(RST), .req(req), .op(op), .din(din),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .ovf(ovf), .err(err), .jk_j(jk_j), .jk_k(jk_k), .jk_en(jk_en),
      .jk_rst_n(jk_rst_n), .q_in(q_in)
   );

   always #5 CLK = ~CLK;

   // JK cell bank: Q+ = J&~Q | ~K&Q, cleared by the active-low reset.
   always @(posedge CLK or negedge jk_rst_n) begin
      if (!jk_rst_n) bank <= '0;
      else if (jk_en)
         for (int i = 0; i < W; i++) bank[i] <= (jk_j[i] & ~bank[i]) | (~jk_k[i] & bank[i]);
   end
   assign q_in = bank;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Arithmetic reference for one operation applied to the model register m.
   task automatic model(input logic [2:0] o, input logic [W-1:0] d);
      int v;
      v = int'(m);
      m_ovf = 1'b0;
      m_err = 1'b0;
      case (o)
         3'd0: v = 0;
         3'd1: v = int'(d);
         3'd2: begin m_ovf = (v == int'(MASK)); v = (v + 1) % (1 << W); end
         3'd3: begin m_ovf = (v == 0); v = (v + (1 << W) - 1) % (1 << W); end
         3'd4: begin m_ovf = ((v >> (W-1)) & 1) == 1; v = ((v * 2) + (int'(d) & 1)) % (1 << W); end
         3'd5: begin m_ovf = (v & 1) == 1; v = (v / 2) + (((int'(d) >> (W-1)) & 1) << (W-1)); end
         3'd6: v = int'(MASK) - v;
         default: m_err = 1'b1;
      endcase
      m = v[W-1:0];
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] d);
      int guard;
      int en_cnt;
      guard = 0;
      while (ready !== 1'b1 && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      check("ready_before_op", ready, 1);
      model(o, d);
      req = 1'b1; op = o; din = d;
      @(negedge CLK);
      req = 1'b0; op = $urandom_range(0, 7); din = $urandom;
      en_cnt = 0;
      check("busy_apply", busy, 1);
      check("done_apply", done, 0);
      if (jk_en === 1'b1) en_cnt++;
      @(negedge CLK);
      check("done_check", done, 0);
      if (jk_en === 1'b1) en_cnt++;
      @(negedge CLK);
      if (jk_en === 1'b1) en_cnt++;
      check("done_pulse", done, 1);
      check("result", result, m);
      check("ovf", ovf, m_ovf);
      check("err", err, m_err);
      @(negedge CLK);
      check("ready_after", ready, 1);
      check("done_clear", done, 0);
      check("jk_en_cycles", en_cnt, (o == 3'd7) ? 0 : 1);
   endtask

   initial begin
      int accepts;
      int dones;
      logic [W-1:0] seen [$];

      // reset state
      repeat (2) @(negedge CLK);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err", err, 0);
      check("rst_jk", {jk_j, jk_k, jk_en}, 0);
      check("rst_jk_rst_n", jk_rst_n, 0);
      RST = 1'b0;
      #1 check("rel_jk_rst_n", jk_rst_n, 1);
      @(negedge CLK);

      // directed sequences
      run_op(3'd1, 4'hA);
      run_op(3'd1, 4'hF); run_op(3'd2, 4'h0); run_op(3'd3, 4'h0);
      run_op(3'd1, 4'h9); run_op(3'd4, 4'h1); run_op(3'd5, 4'h0);
      run_op(3'd1, 4'h5); run_op(3'd6, 4'h0); run_op(3'd7, 4'h3);
      run_op(3'd0, 4'hF);

      // req held high: only accepts while ready
      accepts = 0; dones = 0;
      req = 1'b1; op = 3'd2; din = '0;
      for (int c = 0; c < 8; c++) begin
         if (ready === 1'b1) accepts++;
         if (done === 1'b1) begin dones++; seen.push_back(result); end
         @(negedge CLK);
         if (c == 7) req = 1'b0;
      end
      check("held_accepts", accepts, 2);
      check("held_dones", dones, 2);
      if (seen.size() == 2) begin
         check("held_res0", seen[0], 1);
         check("held_res1", seen[1], 2);
      end else check("held_seen", seen.size(), 2);
      m = 4'h2;
      repeat (4) @(negedge CLK);

      // reset during CHECK aborts the op
      run_op(3'd1, 4'h6);
      req = 1'b1; op = 3'd2;
      @(negedge CLK);
      req = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("abort_jk_rst_n", jk_rst_n, 0);
      check("abort_ready", ready, 1);
      dones = 0;
      repeat (3) begin
         @(negedge CLK);
         if (done === 1'b1) dones++;
      end
      RST = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (done === 1'b1) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_ready_after", ready, 1);
      check("abort_result", result, 0);
      check("abort_bank", q_in, 0);
      m = '0;
      run_op(3'd2, 4'h0);

      // randomized ops
      for (int n = 0; n < 40; n++) run_op(3'($urandom_range(0, 7)), W'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
